// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode enum, status bit indices and status struct for the
//                pipelined ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_SUB    = 2'd0,
        ALU_LESS   = 2'd1,
        ALU_INDB   = 2'd2,
        ALU_CHANGE = 2'd3
    } alu_op_e;

    localparam int unsigned STAT_ERR  = 0;
    localparam int unsigned STAT_ODD  = 1;
    localparam int unsigned STAT_ONES = 2;
    localparam int unsigned STAT_OVF  = 3;

    // Field order matches the STAT_* indices (MSB first in a packed struct).
    typedef struct packed {
        logic ovf;
        logic ones;
        logic odd;
        logic err;
    } alu_status_t;

endpackage
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : alu_datapath
//  Description : Combinational ALU: (op, A, B) -> (result, status flags).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned M = 8,
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]  i_op,
    input  logic [M-1:0]  i_a,
    input  logic [M-1:0]  i_b,
    output logic [M-1:0]  o_result,
    output alu_status_t   o_status
);

    logic [M+1:0] w_diff;
    logic [M-1:0] w_sum;
    logic [M-1:0] w_bit_mask;
    logic [M-1:0] w_mag;
    logic         w_illegal;
    logic         w_idx_ok;
    logic         w_a_min;

    // A - 2B evaluated in M+2 bits so the true value is always representable.
    assign w_diff     = {{2{i_a[M-1]}}, i_a} - {i_b[M-1], i_b, 1'b0};
    assign w_sum      = i_a + i_b;
    assign w_bit_mask = {{(M-1){1'b0}}, 1'b1} << i_b;
    assign w_idx_ok   = (32'(i_b) < M);
    assign w_mag      = i_a[M-1] ? (~i_a + 1'b1) : i_a;
    assign w_a_min    = (i_a == {1'b1, {(M-1){1'b0}}});
    assign w_illegal  = ((i_op >> 2) != '0);

    always_comb begin
        o_result = '0;
        o_status = '0;
        if (w_illegal) begin
            o_status.err = 1'b1;
        end else begin
            case (alu_op_e'(i_op[1:0]))
                ALU_SUB: begin
                    o_result     = w_diff[M-1:0];
                    o_status.ovf = (w_diff[M+1] != w_diff[M]) || (w_diff[M] != w_diff[M-1]);
                end
                ALU_LESS: begin
                    o_result = {{(M-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
                end
                ALU_INDB: begin
                    if (w_idx_ok) begin
                        o_result = {{(M-1){1'b0}}, ~|(w_sum & w_bit_mask)};
                    end else begin
                        o_status.err = 1'b1;
                    end
                end
                ALU_CHANGE: begin
                    // |A| < 2^(M-1) whenever A is legal, so OR-ing in the sign is exact.
                    if (w_a_min) begin
                        o_status.err = 1'b1;
                    end else begin
                        o_result = w_mag | {i_a[M-1], {(M-1){1'b0}}};
                    end
                end
                default: begin
                    o_status.err = 1'b1;
                end
            endcase
        end
        o_status.odd  = ^o_result;
        o_status.ones = &o_result;
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_core
//  Description : Two-stage valid/ready pipelined ALU with saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int unsigned M     = 8,
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_op,
    input  logic [M-1:0]     i_arg_A,
    input  logic [M-1:0]     i_arg_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M-1:0]     o_result,
    output logic [3:0]       o_status,
    output logic [CNT_W-1:0] o_err_cnt
);

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_op;
    logic [M-1:0]     r_s1_a;
    logic [M-1:0]     r_s1_b;
    logic             r_s2_valid;
    logic [M-1:0]     r_result;
    alu_status_t      r_status;
    logic [CNT_W-1:0] r_err_cnt;

    logic [M-1:0]     w_dp_result;
    alu_status_t      w_dp_status;
    logic             w_s2_adv;
    logic             w_out_xfer;

    alu_datapath #(
        .M (M),
        .N (N)
    ) u_datapath (
        .i_op     (r_s1_op),
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_result (w_dp_result),
        .o_status (w_dp_status)
    );

    // No skid buffer: ready depends combinationally on downstream i_ready.
    assign w_s2_adv   = !r_s2_valid || i_ready;
    assign o_ready    = !r_s1_valid || w_s2_adv;
    assign w_out_xfer = r_s2_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_status   <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (o_ready) begin
                r_s1_valid <= i_valid;
                if (i_valid) begin
                    r_s1_op <= i_op;
                    r_s1_a  <= i_arg_A;
                    r_s1_b  <= i_arg_B;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_dp_result;
                    r_status <= w_dp_status;
                end
            end
            if (w_out_xfer && r_status.err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_valid   = r_s2_valid;
    assign o_result  = r_result;
    assign o_status  = r_status;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe_core
//  Description : Directed self-checking bench for alu_pipe_core (M=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_core;

    logic       i_clk;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [7:0] i_arg_A;
    logic [7:0] i_arg_B;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_result;
    logic [3:0] o_status;
    logic [7:0] o_err_cnt;

    logic       s_valid;
    logic       s_ready_o;
    logic [1:0] s_op;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic       s_valid_o;
    logic [7:0] s_result;
    logic [3:0] s_status;
    logic [1:0] s_err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    alu_pipe_core #(.M(8), .N(2), .CNT_W(8)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_op      (i_op),
        .i_arg_A   (i_arg_A),
        .i_arg_B   (i_arg_B),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_status  (o_status),
        .o_err_cnt (o_err_cnt)
    );

    alu_pipe_core #(.M(8), .N(2), .CNT_W(2)) dut_sat (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (s_valid),
        .o_ready   (s_ready_o),
        .i_op      (s_op),
        .i_arg_A   (s_a),
        .i_arg_B   (s_b),
        .o_valid   (s_valid_o),
        .i_ready   (1'b1),
        .o_result  (s_result),
        .o_status  (s_status),
        .o_err_cnt (s_err_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Issue one op and wait (bounded) for its result; lat counts edges from issue.
    task automatic send_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] res, output logic [3:0] st, output int lat);
        i_op = op; i_arg_A = a; i_arg_B = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        res = o_result;
        st  = o_status;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = '0; i_arg_A = '0; i_arg_B = '0;
        s_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        total++; if (o_result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", o_result); end
        total++; if (o_status !== 4'h0) begin bad++; $display("FAIL reset_status got=%b want=0000", o_status); end
        total++; if (o_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", o_err_cnt); end
    endtask

    // Runs a vector table through the core with inline checks of latency, result, status, count.
    task automatic run_table(input string tag, input logic [1:0] ops[], input logic [7:0] as[],
                             input logic [7:0] bs[], input logic [7:0] ers[], input logic [3:0] ess[]);
        logic [7:0] r;
        logic [3:0] s;
        int lat;
        for (int i = 0; i < ops.size(); i++) begin
            send_op(ops[i], as[i], bs[i], r, s, lat);
            total++; if (lat !== 2) begin bad++; $display("FAIL %s_lat[%0d] got=%0d want=2", tag, i, lat); end
            total++; if (r !== ers[i]) begin bad++; $display("FAIL %s_result[%0d] got=%h want=%h", tag, i, r, ers[i]); end
            total++; if (s !== ess[i]) begin bad++; $display("FAIL %s_status[%0d] got=%b want=%b", tag, i, s, ess[i]); end
            @(posedge i_clk); #1;
            if (ess[i][0]) exp_cnt++;
            total++; if (o_err_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL %s_cnt[%0d] got=%0d want=%0d", tag, i, o_err_cnt, exp_cnt); end
        end
    endtask

    task automatic test_sub();
        run_table("sub", '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                  '{8'd10, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00},
                  '{8'd3,  8'h01, 8'h80, 8'h00, 8'h40, 8'hC0},
                  '{8'h04, 8'h7E, 8'h7F, 8'hFF, 8'h80, 8'h80},
                  '{4'b0010, 4'b1000, 4'b1010, 4'b0100, 4'b0010, 4'b1010});
    endtask

    task automatic test_less_indb();
        run_table("li", '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2},
                  '{8'hFF, 8'h01, 8'd3, 8'h70, 8'd1, 8'd1},
                  '{8'h01, 8'hFF, 8'd2, 8'd7,  8'd9, 8'd8},
                  '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00},
                  '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0001});
    endtask

    task automatic test_change();
        run_table("chg", '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3},
                  '{8'hFB, 8'h80, 8'h81, 8'h7F, 8'h00},
                  '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  '{8'h85, 8'h00, 8'hFF, 8'h7F, 8'h00},
                  '{4'b0010, 4'b0001, 4'b0100, 4'b0010, 4'b0000});
    endtask

    task automatic test_back_to_back();
        logic [1:0] t_op[4] = '{2'd0, 2'd1, 2'd0, 2'd3};
        logic [7:0] t_a[4]  = '{8'd20, 8'h01, 8'd5, 8'h07};
        logic [7:0] t_b[4]  = '{8'd3,  8'hFF, 8'd1, 8'h00};
        logic [7:0] t_r[4]  = '{8'h0E, 8'h00, 8'h03, 8'h07};
        int k = 0;
        int got = 0;
        logic rdy, out_x;
        logic [7:0] cur;
        i_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc == 8) i_ready = 1'b1;
            i_valid = (k < 4);
            if (k < 4) begin i_op = t_op[k]; i_arg_A = t_a[k]; i_arg_B = t_b[k]; end
            #1;
            rdy = o_ready; out_x = o_valid && i_ready; cur = o_result;
            if (cyc >= 2 && cyc < 8) begin
                total++; if (o_valid !== 1'b1 || cur !== 8'h0E) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/0e", cyc, o_valid, cur); end
            end
            @(posedge i_clk); #1;
            if (i_valid && rdy) k++;
            if (out_x) begin
                total++; if (cur !== t_r[got]) begin bad++; $display("FAIL bp_order[%0d] got=%h want=%h", got, cur, t_r[got]); end
                got++;
            end
            if (cyc == 7) begin
                total++; if (k !== 2) begin bad++; $display("FAIL bp_accepts got=%0d want=2", k); end
            end
        end
        i_valid = 1'b0;
        total++; if (got !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got); end
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b want=0", o_valid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic [3:0] s;
        int lat;
        logic seen = 1'b0;
        i_ready = 1'b0;
        send_op(2'd0, 8'd10, 8'd3, r, s, lat);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b want=1", o_valid); end
        total++; if (o_err_cnt !== 8'd3) begin bad++; $display("FAIL rm_pre_cnt got=%0d want=3", o_err_cnt); end
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", o_valid); end
        total++; if (o_err_cnt !== 8'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", o_err_cnt); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", o_ready); end
        i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_ghost got=%b want=0", seen); end
        send_op(2'd0, 8'd1, 8'd0, r, s, lat);
        total++; if (r !== 8'h01 || s !== 4'b0010) begin bad++; $display("FAIL rm_after got=%h/%b want=01/0010", r, s); end
        @(posedge i_clk); #1;
        exp_cnt = 0;
    endtask

    task automatic test_saturation();
        logic [1:0] want[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        int w;
        for (int i = 0; i < 5; i++) begin
            s_op = 2'd2; s_a = 8'd1; s_b = 8'd9; s_valid = 1'b1;
            @(posedge i_clk); #1;
            s_valid = 1'b0;
            w = 0;
            while (!s_valid_o && w < 20) begin
                @(posedge i_clk); #1;
                w++;
            end
            total++; if (s_valid_o !== 1'b1 || s_status[0] !== 1'b1) begin bad++; $display("FAIL sat_out[%0d] got=%b/%b want=1/1", i, s_valid_o, s_status[0]); end
            @(posedge i_clk); #1;
            total++; if (s_err_cnt !== want[i]) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, s_err_cnt, want[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_less_indb();
        test_change();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
